// File: rtl/tpu_host_loader.sv
// Host-side loader for the TPU: streams data/weight words into SRAM, kicks the array,
// waits for completion under a timeout and streams the result matrix back out.
module tpu_host_loader #(
  parameter int datawith    = 16,
  parameter int array_size  = 2,
  parameter int DATA_BASE   = 0,
  parameter int WEIGHT_BASE = 4,
  parameter int RESULT_BASE = 8,
  parameter int TIMEOUT     = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  input  logic [datawith-1:0] s_data,
  output logic                s_ready,
  output logic [9:0]          sram_addr,
  output logic [datawith-1:0] sram_wdata,
  output logic                write_en,
  input  logic [datawith-1:0] sram_rdata,
  output logic [3:0]          data_size,
  output logic                tpu_start,
  input  logic                tpu_done,
  output logic                m_valid,
  output logic [datawith-1:0] m_data,
  output logic                m_last,
  input  logic                m_ready,
  output logic                busy,
  output logic                error
);

  localparam int NN = array_size * array_size;
  localparam int KW = $clog2(2 * NN);

  localparam logic [KW-1:0] K_LAST   = KW'(2 * NN - 1);
  localparam logic [KW-1:0] K_NN     = KW'(NN);
  localparam logic [KW-1:0] R_LAST   = KW'(NN - 1);
  localparam logic [9:0]    DATA_A   = 10'(DATA_BASE);
  localparam logic [9:0]    WEIGHT_A = 10'(WEIGHT_BASE);
  localparam logic [9:0]    RESULT_A = 10'(RESULT_BASE);
  localparam logic [9:0]    TO_LAST  = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_START,
    S_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [KW-1:0]       r_q, r_d;
  logic [9:0]          cnt_q, cnt_d;
  logic                s_ready_q, s_ready_d;
  logic [9:0]          addr_q, addr_d;
  logic [datawith-1:0] wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [datawith-1:0] mdata_q, mdata_d;
  logic                error_q, error_d;

  logic                s_hs;
  logic [9:0]          load_addr;

  assign s_hs = s_valid && s_ready_q;

  // Data words occupy the first N*N load slots, weights the next N*N.
  always_comb begin
    load_addr = DATA_A + 10'(k_q);
    if (k_q >= K_NN) begin
      load_addr = WEIGHT_A + 10'(k_q - K_NN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      mdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      mdata_q   <= mdata_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    mdata_d = mdata_q;
    error_d = error_q;

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (s_hs) begin
          we_d    = 1'b1;
          wdata_d = s_data;
          addr_d  = load_addr;
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = S_FLUSH;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (tpu_done) begin
          r_d     = '0;
          addr_d  = RESULT_A;
          state_d = S_RD_REQ;
        end else if (cnt_q == TO_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        mdata_d = sram_rdata;
        state_d = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (m_ready) begin
          if (r_q == R_LAST) begin
            state_d = S_IDLE;
          end else begin
            r_d     = r_q + KW'(1);
            addr_d  = RESULT_A + 10'(r_q) + 10'd1;
            state_d = S_RD_REQ;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    s_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
  end

  assign s_ready    = s_ready_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign write_en   = we_q;
  assign data_size  = 4'(array_size);
  assign tpu_start  = (state_q == S_START);
  assign m_valid    = (state_q == S_RD_OUT);
  assign m_data     = mdata_q;
  assign m_last     = (state_q == S_RD_OUT) && (r_q == R_LAST);
  assign busy       = (state_q != S_IDLE);
  assign error      = error_q;

endmodule

// File: tb/tb_tpu_host_loader.sv
// Scenario bench for tpu_host_loader: write and result scoreboards, timeout and reset cases.
module tb_tpu_host_loader;

  localparam int DW = 16;
  localparam int N  = 2;
  localparam int NN = N * N;
  localparam int DB = 0;
  localparam int WB = 4;
  localparam int RB = 8;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [9:0]    sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          write_en;
  logic [DW-1:0] sram_rdata = '0;
  logic [3:0]    data_size;
  logic          tpu_start;
  logic          tpu_done;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic          error;

  typedef struct packed {
    logic [9:0]    a;
    logic [DW-1:0] d;
    logic [31:0]   c;
  } wr_t;

  wr_t           exp_wr[$];
  logic [DW-1:0] exp_rd[$];
  int            checks = 0;
  int            errors = 0;

  tpu_host_loader #(
    .datawith(DW), .array_size(N), .DATA_BASE(DB), .WEIGHT_BASE(WB),
    .RESULT_BASE(RB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .write_en(write_en),
    .sram_rdata(sram_rdata), .data_size(data_size),
    .tpu_start(tpu_start), .tpu_done(tpu_done),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Result region model: one-cycle read latency, contents 0x0A00 + address.
  always @(posedge clk) sram_rdata <= 16'h0A00 + {6'd0, sram_addr};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] exp_addr(input int i);
    if (i < NN) return 10'(DB + i);
    return 10'(WB + i - NN);
  endfunction

  task automatic test_reset();
    logic [48:0] v;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; tpu_done = 1'b0; m_ready = 1'b0;
    tick(); tick();
    v = {s_ready, sram_addr, sram_wdata, write_en, tpu_start, m_valid, m_data, m_last, busy, error};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", v); end
    checks++;
    if (data_size !== 4'd2) begin errors++; $display("FAIL data_size got %0d want 2", data_size); end
    rst = 1'b0;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b want 0", s_ready); end
    tick();
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ready_after_release got rdy=%b busy=%b want 1 0", s_ready, busy);
    end
  endtask

  // Loads 2*N*N words; returns in the first WAIT cycle.
  task automatic test_load(input bit bubbles);
    int  cyc, idx, last_acc, starts, start_cyc;
    wr_t w;
    cyc = 0; idx = 0; last_acc = -10; starts = 0; start_cyc = -1;
    while (1) begin
      if (write_en === 1'b1) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL extra_write got addr %h data %h want no write", sram_addr, sram_wdata);
        end else begin
          w = exp_wr.pop_front();
          if (sram_addr !== w.a || sram_wdata !== w.d || cyc !== int'(w.c) + 1) begin
            errors++;
            $display("FAIL load_write got addr %h data %h cyc %0d want addr %h data %h cyc %0d",
                     sram_addr, sram_wdata, cyc, w.a, w.d, int'(w.c) + 1);
          end
        end
      end
      if (tpu_start === 1'b1) begin starts++; start_cyc = cyc; end
      if (idx == 2 * NN && cyc == last_acc + 3) break;
      if (cyc > 80) begin
        checks++; errors++;
        $display("FAIL load_timeout got %0d accepts want %0d", idx, 2 * NN);
        break;
      end
      s_valid  = (idx < 2 * NN) && (!bubbles || (cyc % 2 == 0));
      s_data   = 16'h0011 + 16'(idx);
      tpu_done = bubbles && (idx < 2 * NN);
      if (s_valid && s_ready) begin
        exp_wr.push_back({exp_addr(idx), s_data, 32'(cyc)});
        if (idx == 2 * NN - 1) last_acc = cyc;
        idx++;
      end
      tick();
      cyc++;
    end
    s_valid = 1'b0; tpu_done = 1'b0;
    checks++;
    if (starts !== 1 || start_cyc !== last_acc + 2) begin
      errors++;
      $display("FAIL start_pulse got count %0d cyc %0d want 1 cyc %0d", starts, start_cyc, last_acc + 2);
    end
    checks++;
    if (busy !== 1'b1 || tpu_start !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL wait_entry got busy %b start %b rdy %b want 1 0 0", busy, tpu_start, s_ready);
    end
    checks++;
    if (exp_wr.size() != 0) begin
      errors++; $display("FAIL missing_writes got %0d pending want 0", exp_wr.size());
      exp_wr.delete();
    end
  endtask

  // Starts in the first WAIT cycle; done is raised done_at cycles later.
  task automatic test_readback(input int done_at, input int bp, input bit exp_err);
    int cyc, d, nv, stall, word;
    cyc = 0; m_ready = 1'b0; tpu_done = 1'b0;
    while (cyc < done_at) begin tick(); cyc++; end
    tpu_done = 1'b1; d = cyc;
    for (int i = 0; i < NN; i++) exp_rd.push_back(16'h0A00 + 16'(RB + i));
    tick(); cyc++;
    tpu_done = 1'b0;
    checks++;
    if (sram_addr !== 10'(RB)) begin
      errors++; $display("FAIL rd_req_addr got %h want %h", sram_addr, 10'(RB));
    end
    nv = d + 3; stall = 0; word = 0;
    while (exp_rd.size() > 0) begin
      if (cyc > d + 60) begin
        checks++; errors++;
        $display("FAIL readback_timeout got %0d pending want 0", exp_rd.size());
        exp_rd.delete();
        break;
      end
      checks++;
      if (cyc < nv) begin
        if (m_valid !== 1'b0) begin errors++; $display("FAIL early_valid cyc %0d got 1 want 0", cyc); end
      end else begin
        if (m_valid !== 1'b1 || m_data !== exp_rd[0] || m_last !== (exp_rd.size() == 1)) begin
          errors++;
          $display("FAIL result_word got v %b data %h last %b want 1 %h %b",
                   m_valid, m_data, m_last, exp_rd[0], exp_rd.size() == 1);
        end
        if (m_valid === 1'b1) begin
          if (word == 1 && stall < bp) begin
            m_ready = 1'b0; stall++;
            checks++;
            if (sram_addr !== 10'(RB + 1)) begin
              errors++; $display("FAIL stall_addr got %h want %h", sram_addr, 10'(RB + 1));
            end
          end else begin
            m_ready = 1'b1;
            void'(exp_rd.pop_front());
            word++;
            nv = cyc + 3;
          end
        end
      end
      tick(); cyc++;
      m_ready = 1'b0;
    end
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || error !== exp_err) begin
      errors++;
      $display("FAIL readback_end got busy %b v %b err %b want 0 0 %b", busy, m_valid, error, exp_err);
    end
  endtask

  task automatic test_back_to_back();
    test_load(1'b0);
    test_readback(5, 0, 1'b0);
  endtask

  task automatic test_bubbles_backpressure();
    test_load(1'b1);
    test_readback(5, 4, 1'b0);
  endtask

  task automatic test_timeout();
    test_load(1'b0);
    for (int c = 0; c < TO; c++) begin
      checks++;
      if (busy !== 1'b1 || error !== 1'b0) begin
        errors++; $display("FAIL timeout_wait cyc %0d got busy %b err %b want 1 0", c, busy, error);
      end
      tick();
    end
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_exit got err %b busy %b rdy %b want 1 0 1", error, busy, s_ready);
    end
    test_load(1'b0);
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL error_sticky got %b want 1", error); end
    test_readback(3, 0, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    int          acc, cyc;
    logic [48:0] v;
    acc = 0; cyc = 0;
    s_valid = 1'b1;
    while (acc < 3 && cyc < 20) begin
      s_data = 16'h0100 + 16'(acc);
      if (s_ready) acc++;
      tick(); cyc++;
    end
    if (acc != 3) begin checks++; errors++; $display("FAIL partial_load got %0d want 3", acc); end
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    v = {s_ready, sram_addr, sram_wdata, write_en, tpu_start, m_valid, m_data, m_last, busy, error};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL async_reset got %h want 0", v); end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset got rdy %b busy %b want 1 0", s_ready, busy);
    end
    exp_wr.delete();
    test_load(1'b0);
    // Done lands in the same cycle the timeout would fire.
    test_readback(TO - 1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles_backpressure();
    test_timeout();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_host_loader.md
# tpu_host_loader

Host-side initiator for the TPU's SRAM load port and result readback path. It accepts a valid/ready stream of data and weight words and writes them into the TPU SRAM at fixed base addresses. It then pulses `tpu_start`, waits for `tpu_done` under a timeout, and streams the result matrix back out of the SRAM on a valid/ready master port. It sits between the testbench/host and the `tpuv1` SRAM port (`write_addr`/`data_in`/`write_en`).

## Interface
- `datawith`, 16, word width
- `array_size`, 2, N; each matrix is N*N words
- `DATA_BASE`, 0, SRAM address of data word 0
- `WEIGHT_BASE`, 4, SRAM address of weight word 0
- `RESULT_BASE`, 8, SRAM address of result word 0
- `TIMEOUT`, 1023, max WAIT cycles before error (10-bit counter)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `s_valid`  in  1  input word valid
- `s_data`  in  datawith  input word (N*N data words, then N*N weight words)
- `s_ready`  out  1  loader accepts word
- `sram_addr`  out  10  SRAM address (drives TPU `write_addr`)
- `sram_wdata`  out  datawith  SRAM write data (drives TPU `data_in`)
- `write_en`  out  1  SRAM write strobe
- `sram_rdata`  in  datawith  SRAM read data, valid one cycle after address
- `data_size`  out  4  constant `array_size[3:0]`
- `tpu_start`  out  1  one-cycle start pulse
- `tpu_done`  in  1  TPU completion, level or pulse
- `m_valid`  out  1  result word valid
- `m_data`  out  datawith  result word
- `m_last`  out  1  high with last result word
- `m_ready`  in  1  sink accepts result
- `busy`  out  1  high in every state except IDLE
- `error`  out  1  sticky timeout flag, cleared only by `rst`

## Operation
- States: IDLE, LOAD, FLUSH, START, WAIT, RD_REQ, RD_WAIT, RD_OUT.
- IDLE and LOAD:
  - `s_ready`=1. Each handshake (`s_valid && s_ready`) increments load count k (0..2N*N-1).
  - The first handshake moves the FSM to LOAD.
  - Write is registered: the cycle after the handshake, `write_en`=1 and `sram_wdata`=accepted word.
  - `sram_addr` = DATA_BASE+k for k<N*N, otherwise WEIGHT_BASE+(k-N*N).
- Accepting word k=2N*N-1 moves the FSM to FLUSH. `s_ready`=0 from then until the next IDLE.
- FLUSH: the last write is performed. Next state is START.
- START: `tpu_start`=1 for exactly one cycle, `write_en`=0. Next state is WAIT; the timeout counter clears.
- WAIT:
  - Counter increments each cycle.
  - `tpu_done`=1 moves the FSM to RD_REQ with result index r=0.
  - If the counter reaches TIMEOUT without done, `error` is set to 1 and the FSM returns to IDLE.
  - If done and timeout occur in the same cycle, done wins and `error` stays 0.
- RD_REQ: `sram_addr`=RESULT_BASE+r, `write_en`=0. Next state is RD_WAIT.
- RD_WAIT: `m_data` is loaded from `sram_rdata` at the cycle end. Next state is RD_OUT.
- RD_OUT:
  - `m_valid`=1, and `m_last`=(r==N*N-1).
  - `m_data` is held stable until `m_ready`.
  - On handshake: if r<N*N-1, r increments and the FSM goes to RD_REQ; otherwise it goes to IDLE.
- Address arithmetic is 10-bit. Configurations with base+N*N-1 > 1023 are unsupported.
- `sram_addr` holds its last value outside write and RD_REQ cycles. It is 0 after reset.

## Timing
- Reset values: `s_ready`=0, `sram_addr`=0, `sram_wdata`=0, `write_en`=0, `tpu_start`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `error`=0. The FSM resets to IDLE and all counters to 0.
- `s_ready` is registered 1 from the first cycle after reset release.
- Last input accepted in cycle t:
  - `write_en` high in t+1 (FLUSH).
  - `tpu_start` high in t+2 only.
  - WAIT starts at t+3.
- `tpu_done` sampled high in cycle d: RD_REQ at d+1, `m_valid` from d+3.
- Readback throughput: handshake in cycle h means the next `m_valid` rises at h+3.
- `tpu_done` outside WAIT is ignored.
- `rst` asserted mid-operation aborts immediately. Partially loaded SRAM contents are not cleaned up.

## Test plan
- Load, N=2: 8 words 0x0011..0x0018, `s_valid` held high. Expect:
  - writes at addresses 0..3 = 0x0011..0x0014, and 4..7 = 0x0015..0x0018;
  - `tpu_start` pulses once, 2 cycles after the last accept.
- Input bubbles: `s_valid` toggled 1010… Expect the same 8 writes with correct addresses and no duplicate `write_en`.
- Readback: SRAM model returns 0x0A00+addr; `tpu_done` 5 cycles into WAIT; `m_ready`=1. Expect:
  - `m_data` 0x0A08..0x0A0B;
  - `m_last` only on 0x0A0B;
  - `busy` falls after the last handshake.
- Backpressure: `m_ready` low 4 cycles on word 1. Expect `m_data` held at 0x0A09 with `m_valid` high, and no address advance.
- Timeout: TIMEOUT=20, `tpu_done` never asserted. Expect `error`=1 after 20 WAIT cycles, return to IDLE, `error` still 1 on the next load. Variant: `tpu_done` in the same cycle as timeout. Expect readback and `error`=0.
- Reset mid-LOAD after 3 words: all outputs at reset values within the same cycle (async). A full reload then behaves as in scenario 1.
